reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//  32-entry MIPS general-purpose register file with two read ports and one staged write-back port.
//  Read ports A/B drive the operand latch ahead of the ALU.
//  The write port takes the result from the write-back stage (ALUOut or MDR, selected upstream).
//  Writes are captured into a one-entry pending stage, then committed to the array on the next edge.
//  An optional bypass path makes a pending write visible to readers before it commits.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   register index width; depth = 2**ADDR_W
//  BYPASS  1   1: reads forward pending write data; 0: reads see committed array only
// PORTS
//  clk       in   1       clock; all state updates on rising edge
//  rst       in   1       asynchronous reset, active-high
//  we        in   1       write request this cycle (RegWrite)
//  waddr     in   ADDR_W  destination register index
//  wdata     in   DATA_W  write-back data
//  raddr_a   in   ADDR_W  read index, port A (rs)
//  raddr_b   in   ADDR_W  read index, port B (rt)
//  rdata_a   out  DATA_W  read data, port A (combinational)
//  rdata_b   out  DATA_W  read data, port B (combinational)
//  dbg_addr  in   ADDR_W  debug read index
//  dbg_data  out  DATA_W  debug read data from committed array, no bypass
//  wb_pend   out  1       high while a write sits in the pending stage
// BEHAVIOUR
//  Reset (async, rst=1):
//   - All array entries, pend_valid, pend_addr and pend_data clear to 0 immediately.
//   - rdata_a, rdata_b and dbg_data read 0; wb_pend=0.
//   - Reset during a pending write discards that write; it never commits.
//  Capture, each rising edge with rst=0:
//   - pend_valid <= we && (waddr != 0).
//   - When that condition holds: pend_addr <= waddr and pend_data <= wdata.
//   - Otherwise pend_addr and pend_data hold their values.
//  Commit, same edge:
//   - If pend_valid was 1 before the edge, mem[pend_addr] <= pend_data.
//   - Commit of the old pending write and capture of a new one happen together, without conflict.
//  Back-to-back writes to the same index commit in order; the array ends with the last value.
//  Register 0:
//   - Always reads 0 on every port.
//   - A write to index 0 is dropped at capture: no pend_valid, no array change.
//  Read mux per port, evaluated in priority order (raddr_x, rdata_x):
//   - raddr_x == 0 -> 0;
//   - else if BYPASS && pend_valid && pend_addr == raddr_x -> pend_data;
//   - else mem[raddr_x].
//  No combinational path from wdata to any read port.
//  Write-to-read latency:
//   - BYPASS=1: visible 1 edge after we=1.
//   - BYPASS=0: visible 2 edges after we=1.
//  Ports A and B may address the same index; both return identical data.
//  wb_pend = pend_valid.
//   - The control FSM holds the next instruction's decode while wb_pend=1 and BYPASS=0.
// TESTING
//  1. Reset: assert rst mid-simulation with no clock edge.
//     -> all read ports 0 immediately; wb_pend=0.
//  2. BYPASS=1: we=1, waddr=5, wdata=32'hDEADBEEF at edge 1; raddr_a=5.
//     -> rdata_a=DEADBEEF after edge 1; dbg_data (dbg_addr=5) stays 0 until after edge 2.
//  3. BYPASS=0, same stimulus as 2.
//     -> rdata_a=0 after edge 1; rdata_a=DEADBEEF after edge 2.
//  4. we=1, waddr=0, wdata=32'h1234 -> wb_pend stays 0; raddr_a=0 reads 0 forever.
//  5. Consecutive writes to r7: 32'h1, then 32'h2.
//     -> after edge 3, mem[7]=2; with BYPASS=1, port B reads 1 after edge 1 and 2 after edge 2.
//  6. we=1, waddr=9, wdata=32'hAA at edge 1; rst pulse before edge 2.
//     -> r9 reads 0 afterwards; wb_pend=0.

Source files
------------

// File: rtl/reg_file_wb.sv
// 32-entry register file with two bypassable read ports, a debug read port and a
// one-entry pending write stage that commits to the array on the following edge.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wb_pend
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              capture_d;

  // Writes to r0 are dropped here, so the pending stage never holds index 0.
  assign capture_d = we && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pend_valid_q <= capture_d;
      if (capture_d) begin
        pend_addr_q <= waddr;
        pend_data_q <= wdata;
      end
      if (pend_valid_q) begin
        mem_q[pend_addr_q] <= pend_data_q;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = mem_q[addr];
    if (addr == '0) begin
      val = '0;
    end else if ((BYPASS != 0) && pend_valid_q && (pend_addr_q == addr)) begin
      val = pend_data_q;
    end
    return val;
  endfunction

  // Forwarding uses only registered pending data, never wdata directly.
  assign rdata_a  = read_port(raddr_a);
  assign rdata_b  = read_port(raddr_b);
  assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
  assign wb_pend  = pend_valid_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: one bypassing and one non-bypassing instance share
// stimulus; expected values are queued by the stimulus and checked by a monitor.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [4:0]  dbg_addr;
  logic [31:0] rdata_a_byp, rdata_b_byp, dbg_data_byp;
  logic [31:0] rdata_a_nb, rdata_b_nb, dbg_data_nb;
  logic        wb_pend_byp, wb_pend_nb;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a_byp), .rdata_b(rdata_b_byp),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_byp), .wb_pend(wb_pend_byp)
  );

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a_nb), .rdata_b(rdata_b_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb), .wb_pend(wb_pend_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  // sel: 0..3 = bypass a/b/dbg/pend, 4..7 = no-bypass a/b/dbg/pend
  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return rdata_a_byp;
      1: return rdata_b_byp;
      2: return dbg_data_byp;
      3: return {31'b0, wb_pend_byp};
      4: return rdata_a_nb;
      5: return rdata_b_nb;
      6: return dbg_data_nb;
      default: return {31'b0, wb_pend_nb};
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    e.name = name;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk or sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        act = observe(e.sel);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end else begin
          $display("ok   %s: %h", e.name, act);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    we = w;
    waddr = wa;
    wdata = wd;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_val(3, 32'h0, "reset_pend_byp");
    expect_val(7, 32'h0, "reset_pend_nb");

    // Write r5 = DEADBEEF: bypass sees it after edge 1, array after edge 2
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    raddr_a = 5'd5; raddr_b = 5'd5; dbg_addr = 5'd5;
    expect_val(0, 32'h0, "r5_pre_byp");
    expect_val(4, 32'h0, "r5_pre_nb");
    drive(1'b0, 5'd0, 32'h0);
    expect_val(0, 32'hDEADBEEF, "r5_e1_a_byp");
    expect_val(1, 32'hDEADBEEF, "r5_e1_b_byp");
    expect_val(2, 32'h0,        "r5_e1_dbg_byp");
    expect_val(3, 32'h1,        "r5_e1_pend_byp");
    expect_val(4, 32'h0,        "r5_e1_a_nb");
    expect_val(6, 32'h0,        "r5_e1_dbg_nb");
    expect_val(7, 32'h1,        "r5_e1_pend_nb");
    drive(1'b0, 5'd0, 32'h0);
    expect_val(0, 32'hDEADBEEF, "r5_e2_a_byp");
    expect_val(2, 32'hDEADBEEF, "r5_e2_dbg_byp");
    expect_val(3, 32'h0,        "r5_e2_pend_byp");
    expect_val(4, 32'hDEADBEEF, "r5_e2_a_nb");
    expect_val(5, 32'hDEADBEEF, "r5_e2_b_nb");
    expect_val(6, 32'hDEADBEEF, "r5_e2_dbg_nb");
    expect_val(7, 32'h0,        "r5_e2_pend_nb");

    // Back-to-back writes to r7: 1 then 2
    drive(1'b1, 5'd7, 32'h1);
    raddr_b = 5'd7; dbg_addr = 5'd7;
    expect_val(1, 32'h0, "r7_pre_b_byp");
    drive(1'b1, 5'd7, 32'h2);
    expect_val(1, 32'h1, "r7_e1_b_byp");
    expect_val(5, 32'h0, "r7_e1_b_nb");
    drive(1'b0, 5'd0, 32'h0);
    expect_val(1, 32'h2, "r7_e2_b_byp");
    expect_val(5, 32'h1, "r7_e2_b_nb");
    expect_val(6, 32'h1, "r7_e2_dbg_nb");
    expect_val(7, 32'h1, "r7_e2_pend_nb");
    drive(1'b0, 5'd0, 32'h0);
    expect_val(1, 32'h2, "r7_e3_b_byp");
    expect_val(2, 32'h2, "r7_e3_dbg_byp");
    expect_val(5, 32'h2, "r7_e3_b_nb");
    expect_val(6, 32'h2, "r7_e3_dbg_nb");

    // Back-to-back writes to different registers
    drive(1'b1, 5'd3, 32'h11);
    raddr_a = 5'd3; raddr_b = 5'd4;
    drive(1'b1, 5'd4, 32'h22);
    expect_val(0, 32'h11, "r3_e1_a_byp");
    expect_val(1, 32'h0,  "r4_e1_b_byp");
    drive(1'b0, 5'd0, 32'h0);
    expect_val(0, 32'h11, "r3_e2_a_byp");
    expect_val(4, 32'h11, "r3_e2_a_nb");
    expect_val(1, 32'h22, "r4_e2_b_byp");
    expect_val(5, 32'h0,  "r4_e2_b_nb");
    drive(1'b0, 5'd0, 32'h0);
    expect_val(5, 32'h22, "r4_e3_b_nb");

    // Write to r0 is dropped
    drive(1'b1, 5'd0, 32'h1234);
    raddr_a = 5'd0; dbg_addr = 5'd0;
    drive(1'b0, 5'd0, 32'h0);
    expect_val(0, 32'h0, "r0_e1_a_byp");
    expect_val(3, 32'h0, "r0_e1_pend_byp");
    expect_val(7, 32'h0, "r0_e1_pend_nb");
    drive(1'b0, 5'd0, 32'h0);
    expect_val(0, 32'h0, "r0_e2_a_byp");
    expect_val(4, 32'h0, "r0_e2_a_nb");
    expect_val(2, 32'h0, "r0_e2_dbg_byp");

    // Pending write to r9 discarded by an async reset between edges
    drive(1'b1, 5'd9, 32'hAA);
    raddr_a = 5'd9; raddr_b = 5'd5; dbg_addr = 5'd7;
    @(posedge clk);
    #1 we = 1'b0; waddr = '0; wdata = '0;
    expect_val(0, 32'hAA, "r9_e1_a_byp");
    expect_val(3, 32'h1,  "r9_e1_pend_byp");
    expect_val(4, 32'h0,  "r9_e1_a_nb");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    expect_val(0, 32'h0, "arst_a_byp");
    expect_val(1, 32'h0, "arst_b_byp");
    expect_val(2, 32'h0, "arst_dbg_byp");
    expect_val(3, 32'h0, "arst_pend_byp");
    expect_val(4, 32'h0, "arst_a_nb");
    expect_val(5, 32'h0, "arst_b_nb");
    expect_val(6, 32'h0, "arst_dbg_nb");
    expect_val(7, 32'h0, "arst_pend_nb");
    -> sample_ev;
    @(posedge clk);
    #1 rst = 1'b0;
    dbg_addr = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    expect_val(0, 32'h0, "r9_post_a_byp");
    expect_val(4, 32'h0, "r9_post_a_nb");
    expect_val(2, 32'h0, "r9_post_dbg_byp");
    expect_val(6, 32'h0, "r9_post_dbg_nb");
    expect_val(3, 32'h0, "r9_post_pend_byp");

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
